// File: rtl/fp_exe_scheduler.sv
// Issue and writeback scheduler for the FP execute stage. It reserves writeback slots
// for fixed-latency units and sequences the iterative divider onto the shared port.
module fp_exe_scheduler #(
  parameter int ADD_LAT = 3,
  parameter int MUL_LAT = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       flush,
  input  logic       issue_valid,
  input  logic [1:0] issue_unit,
  output logic       issue_ready,
  output logic       start_misc,
  output logic       start_add,
  output logic       start_mul,
  output logic       start_div,
  input  logic       div_done,
  output logic       div_ack,
  output logic       div_kill,
  output logic       wb_valid,
  output logic [1:0] wb_unit,
  output logic       busy
);

  localparam int MAX_LAT = (ADD_LAT > MUL_LAT) ? ((ADD_LAT > 1) ? ADD_LAT : 1)
                                               : ((MUL_LAT > 1) ? MUL_LAT : 1);

  localparam logic [1:0] U_MISC = 2'd0;
  localparam logic [1:0] U_ADD  = 2'd1;
  localparam logic [1:0] U_MUL  = 2'd2;
  localparam logic [1:0] U_DIV  = 2'd3;

  typedef enum logic [1:0] {D_IDLE, D_BUSY, D_HOLD} div_state_e;

  div_state_e       state_q, state_d;
  logic [MAX_LAT:0] res_q, res_d;
  logic [1:0]       tag_q [MAX_LAT:0];
  logic [1:0]       tag_d [MAX_LAT:0];

  logic active;
  logic slot_busy;
  logic accept;
  logic fix_wb;
  logic div_wb;

  assign active = en & ~flush;
  assign accept = issue_valid & issue_ready;

  // Writeback slot the offered op would claim: res[L] must be empty.
  always_comb begin
    // NOTE: every always_comb assigns its outputs a default first, so no path infers a latch.
    slot_busy = 1'b0;
    case (issue_unit)
      U_MISC:  slot_busy = res_q[1];
      U_ADD:   slot_busy = res_q[ADD_LAT];
      U_MUL:   slot_busy = res_q[MUL_LAT];
      default: slot_busy = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      state_q <= D_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic for the divider handshake.
  always_comb begin
    state_d = state_q;
    if (en) begin
      if (flush) begin
        state_d = D_IDLE;
      end else begin
        case (state_q)
          D_IDLE: if (accept && issue_unit == U_DIV) state_d = D_BUSY;
          D_BUSY: if (div_done) state_d = res_q[0] ? D_HOLD : D_IDLE;
          D_HOLD: if (!res_q[0]) state_d = D_IDLE;
          default: state_d = D_IDLE;
        endcase
      end
    end
  end

  // Outputs: issue handshake, start pulses, writeback mux and divider control.
  always_comb begin
    if (issue_unit == U_DIV) begin
      issue_ready = active & (state_q == D_IDLE);
    end else begin
      issue_ready = active & ~slot_busy & (state_q != D_HOLD);
    end
    start_misc = accept & (issue_unit == U_MISC);
    start_add  = accept & (issue_unit == U_ADD);
    start_mul  = accept & (issue_unit == U_MUL);
    start_div  = accept & (issue_unit == U_DIV);

    // A fixed-latency result always wins the port; the divider waits for a hole.
    fix_wb   = active & res_q[0];
    div_wb   = active & ~res_q[0] &
               (((state_q == D_BUSY) & div_done) | (state_q == D_HOLD));
    wb_valid = fix_wb | div_wb;
    wb_unit  = fix_wb ? tag_q[0] : (div_wb ? U_DIV : 2'd0);
    div_ack  = div_wb;
    div_kill = en & flush & (state_q != D_IDLE);
    busy     = (|res_q) | (state_q != D_IDLE);
  end

  // Reservation vector and tags shift toward slot 0 once per enabled cycle.
  always_comb begin
    res_d = res_q;
    tag_d = tag_q;
    if (en) begin
      if (flush) begin
        res_d = '0;
        for (int i = 0; i <= MAX_LAT; i++) tag_d[i] = 2'd0;
      end else begin
        for (int i = 0; i < MAX_LAT; i++) begin
          res_d[i] = res_q[i+1];
          tag_d[i] = tag_q[i+1];
        end
        res_d[MAX_LAT] = 1'b0;
        tag_d[MAX_LAT] = 2'd0;
        if (accept) begin
          case (issue_unit)
            U_MISC: begin res_d[0]         = 1'b1; tag_d[0]         = U_MISC; end
            U_ADD:  begin res_d[ADD_LAT-1] = 1'b1; tag_d[ADD_LAT-1] = U_ADD;  end
            U_MUL:  begin res_d[MUL_LAT-1] = 1'b1; tag_d[MUL_LAT-1] = U_MUL;  end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q <= '0;
      // NOTE: the tag array is tiny and reset with everything else so wb_unit never goes X.
      for (int i = 0; i <= MAX_LAT; i++) tag_q[i] <= 2'd0;
    end else begin
      res_q <= res_d;
      for (int i = 0; i <= MAX_LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

endmodule

// File: tb/tb_fp_exe_scheduler.sv
// Self-checking bench for fp_exe_scheduler: a due-cycle model checks every output each
// cycle, and directed scenarios pin hand-computed values.
module tb_fp_exe_scheduler;

  localparam int ADD_LAT = 3;
  localparam int MUL_LAT = 2;
  localparam logic [1:0] U_MISC = 2'd0;
  localparam logic [1:0] U_ADD  = 2'd1;
  localparam logic [1:0] U_MUL  = 2'd2;
  localparam logic [1:0] U_DIV  = 2'd3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic       flush = 1'b0;
  logic       issue_valid = 1'b0;
  logic [1:0] issue_unit = 2'd0;
  logic       div_done = 1'b0;
  logic       issue_ready, start_misc, start_add, start_mul, start_div;
  logic       div_ack, div_kill, wb_valid, busy;
  logic [1:0] wb_unit;

  int n_vec  = 0;
  int n_fail = 0;

  fp_exe_scheduler #(.ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .flush(flush),
    .issue_valid(issue_valid), .issue_unit(issue_unit), .issue_ready(issue_ready),
    .start_misc(start_misc), .start_add(start_add), .start_mul(start_mul),
    .start_div(start_div), .div_done(div_done), .div_ack(div_ack), .div_kill(div_kill),
    .wb_valid(wb_valid), .wb_unit(wb_unit), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [1:0] u);
    case (u)
      U_ADD:   return ADD_LAT;
      U_MUL:   return MUL_LAT;
      default: return 1;
    endcase
  endfunction

  // Model: each fixed op is remembered by the enabled-cycle count at which it writes back.
  typedef struct {
    int         due;
    logic [1:0] unit;
  } op_t;

  op_t pend[$];
  int  ecnt = 0;
  bit  div_out = 0;
  bit  div_held = 0;

  always @(negedge clk) begin : compare
    op_t        keep[$];
    logic       act, fix_due, taken, acc, e_rdy, e_fwb, e_dwb, e_wbv, e_kill, e_busy;
    logic [1:0] fix_unit, e_wbu;
    if (!reset_n) begin
      pend.delete();
      ecnt = 0; div_out = 0; div_held = 0;
      check("rst_busy", {1'b0, busy}, 2'd0);
      check("rst_wb_valid", {1'b0, wb_valid}, 2'd0);
      check("rst_div_kill", {1'b0, div_kill}, 2'd0);
    end else begin
      act = en && !flush;
      fix_due = 0; fix_unit = 2'd0; taken = 0;
      foreach (pend[i]) begin
        if (pend[i].due == ecnt) begin fix_due = 1; fix_unit = pend[i].unit; end
        if (pend[i].due == ecnt + lat_of(issue_unit)) taken = 1;
      end
      if (issue_unit == U_DIV) e_rdy = act && !div_out;
      else                     e_rdy = act && !div_held && !taken;
      acc    = issue_valid && e_rdy;
      e_fwb  = act && fix_due;
      e_dwb  = act && div_out && (div_held || div_done) && !fix_due;
      e_wbv  = e_fwb || e_dwb;
      e_wbu  = e_fwb ? fix_unit : (e_dwb ? U_DIV : 2'd0);
      e_kill = en && flush && div_out;
      e_busy = (pend.size() != 0) || div_out;

      check("issue_ready", {1'b0, issue_ready}, {1'b0, e_rdy});
      check("start_misc", {1'b0, start_misc}, {1'b0, acc && issue_unit == U_MISC});
      check("start_add",  {1'b0, start_add},  {1'b0, acc && issue_unit == U_ADD});
      check("start_mul",  {1'b0, start_mul},  {1'b0, acc && issue_unit == U_MUL});
      check("start_div",  {1'b0, start_div},  {1'b0, acc && issue_unit == U_DIV});
      check("wb_valid", {1'b0, wb_valid}, {1'b0, e_wbv});
      check("wb_unit", wb_unit, e_wbu);
      check("div_ack", {1'b0, div_ack}, {1'b0, e_dwb});
      check("div_kill", {1'b0, div_kill}, {1'b0, e_kill});
      check("busy", {1'b0, busy}, {1'b0, e_busy});

      if (en) begin
        if (flush) begin
          pend.delete();
          div_out = 0; div_held = 0;
        end else begin
          keep = {};
          foreach (pend[i]) if (pend[i].due != ecnt) keep.push_back(pend[i]);
          pend = keep;
          if (acc && issue_unit != U_DIV) pend.push_back('{ecnt + lat_of(issue_unit), issue_unit});
          if (acc && issue_unit == U_DIV) div_out = 1;
          if (e_dwb) begin
            div_out = 0; div_held = 0;
          end else if (div_out && div_done) begin
            div_held = 1;
          end
          ecnt++;
        end
      end
    end
  end

  // Drive one cycle of inputs just after the edge, then return just after the falling edge.
  task automatic cyc(input logic e, input logic f, input logic v, input logic [1:0] u,
                     input logic d);
    @(posedge clk);
    #1;
    en = e; flush = f; issue_valid = v; issue_unit = u; div_done = d;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, U_MISC, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // MISC: start at T, writeback at T+1, idle at T+2.
    cyc(1, 0, 1, U_MISC, 0);
    check("s1_start_misc", {1'b0, start_misc}, 2'd1);
    idle(1);
    check("s1_wb_valid", {1'b0, wb_valid}, 2'd1);
    check("s1_wb_unit", wb_unit, U_MISC);
    idle(1);
    check("s1_busy_off", {1'b0, busy}, 2'd0);

    // ADD at T blocks MISC at T+2; MISC accepted at T+3.
    cyc(1, 0, 1, U_ADD, 0);
    check("s2_start_add", {1'b0, start_add}, 2'd1);
    idle(1);
    cyc(1, 0, 1, U_MISC, 0);
    check("s2_misc_blocked", {1'b0, issue_ready}, 2'd0);
    cyc(1, 0, 1, U_MISC, 0);
    check("s2_misc_ready", {1'b0, issue_ready}, 2'd1);
    check("s2_wb_add", wb_unit, U_ADD);
    idle(1);
    check("s2_wb_misc_v", {1'b0, wb_valid}, 2'd1);
    check("s2_wb_misc", wb_unit, U_MISC);

    // MUL at T, ADD at T+1: writebacks at T+2 and T+4.
    cyc(1, 0, 1, U_MUL, 0);
    check("s3_mul_ready", {1'b0, issue_ready}, 2'd1);
    cyc(1, 0, 1, U_ADD, 0);
    check("s3_add_ready", {1'b0, issue_ready}, 2'd1);
    idle(1);
    check("s3_wb_mul", wb_unit, U_MUL);
    idle(1);
    check("s3_gap", {1'b0, wb_valid}, 2'd0);
    idle(1);
    check("s3_wb_add", wb_unit, U_ADD);

    // DIV completes while fixed results occupy the port: hold, then write back.
    cyc(1, 0, 1, U_DIV, 0);
    check("s4_start_div", {1'b0, start_div}, 2'd1);
    idle(6);
    cyc(1, 0, 1, U_ADD, 0);
    idle(1);
    cyc(1, 0, 1, U_MUL, 0);
    check("s4_mul_ready", {1'b0, issue_ready}, 2'd1);
    cyc(1, 0, 0, U_MISC, 1);
    check("s4_wb_add", wb_unit, U_ADD);
    check("s4_no_ack", {1'b0, div_ack}, 2'd0);
    cyc(1, 0, 1, U_MISC, 1);
    check("s4_hold_block", {1'b0, issue_ready}, 2'd0);
    check("s4_wb_mul", wb_unit, U_MUL);
    cyc(1, 0, 1, U_MISC, 1);
    check("s4_div_wb_v", {1'b0, wb_valid}, 2'd1);
    check("s4_div_wb_u", wb_unit, U_DIV);
    check("s4_div_ack", {1'b0, div_ack}, 2'd1);
    idle(1);
    check("s4_busy_off", {1'b0, busy}, 2'd0);

    // Flush kills an in-flight divide; a late div_done is ignored.
    cyc(1, 0, 1, U_DIV, 0);
    idle(3);
    cyc(1, 1, 1, U_MISC, 0);
    check("s5_kill", {1'b0, div_kill}, 2'd1);
    check("s5_flush_rdy", {1'b0, issue_ready}, 2'd0);
    idle(1);
    check("s5_busy_off", {1'b0, busy}, 2'd0);
    cyc(1, 0, 0, U_MISC, 1);
    check("s5_stale_done", {1'b0, wb_valid}, 2'd0);
    cyc(1, 0, 0, U_MISC, 1);
    idle(1);

    // Flush under en=0 is ignored; second DIV refused while MISC still goes.
    cyc(1, 0, 1, U_DIV, 0);
    cyc(0, 1, 0, U_MISC, 0);
    check("s6_frozen_flush", {1'b0, div_kill}, 2'd0);
    cyc(1, 0, 1, U_DIV, 0);
    check("s6_div2_refused", {1'b0, issue_ready}, 2'd0);
    cyc(1, 0, 1, U_MISC, 0);
    check("s6_misc_ok", {1'b0, start_misc}, 2'd1);
    cyc(1, 0, 0, U_MISC, 1);
    check("s6_misc_wins", wb_unit, U_MISC);
    cyc(1, 0, 0, U_MISC, 1);
    check("s6_div_wb", wb_unit, U_DIV);
    idle(1);

    // ADD with two stalled cycles writes back at T+5.
    cyc(1, 0, 1, U_ADD, 0);
    cyc(0, 0, 1, U_MISC, 0);
    check("s7_stall_rdy", {1'b0, issue_ready}, 2'd0);
    cyc(0, 0, 1, U_MISC, 0);
    check("s7_stall_start", {1'b0, start_misc}, 2'd0);
    idle(2);
    check("s7_no_wb_t4", {1'b0, wb_valid}, 2'd0);
    idle(1);
    check("s7_wb_t5", wb_unit, U_ADD);
    check("s7_wb_t5_v", {1'b0, wb_valid}, 2'd1);

    // Mixed pattern with stalls and one flush, checked by the model alone.
    for (int i = 0; i < 30; i++)
      cyc(i % 7 != 5, i == 20, i % 4 != 3, 2'(i % 3), 1'b0);
    idle(4);

    // Reset mid-operation returns to idle immediately without a kill pulse.
    cyc(1, 0, 1, U_DIV, 0);
    cyc(1, 0, 1, U_ADD, 0);
    @(posedge clk);
    #1;
    en = 1'b0; issue_valid = 1'b0; reset_n = 1'b0;
    #1;
    check("s8_rst_busy", {1'b0, busy}, 2'd0);
    check("s8_rst_kill", {1'b0, div_kill}, 2'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle(2);
    check("s8_after_busy", {1'b0, busy}, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
